io_sequencer: RTL

IO_SEQUENCER -- requirements
Module: io_sequencer

---
 rtl/io_seq_pkg.sv | 28 ++
 rtl/sync_edge.sv | 42 ++++
 rtl/io_sequencer.sv | 93 +++++++++
 3 files changed

// File: rtl/io_seq_pkg.sv
// io_seq_pkg: state/phase encoding and phase-class helpers shared by the io_sequencer block.
package io_seq_pkg;

    localparam int PHASE_W = 4;

    typedef enum logic [PHASE_W-1:0] {
        IDLE     = 4'd0,
        REQ_IN   = 4'd1,
        WAIT_IN  = 4'd2,
        REQ_IM   = 4'd3,
        WAIT_IM  = 4'd4,
        RUN      = 4'd5,
        WAIT_RUN = 4'd6,
        REQ_TX   = 4'd7,
        WAIT_TX  = 4'd8,
        DONE     = 4'd9,
        ERROR    = 4'd10
    } state_e;

    function automatic logic is_io_phase(input state_e s);
        return s inside {REQ_IN, WAIT_IN, REQ_IM, WAIT_IM, REQ_TX, WAIT_TX};
    endfunction

    function automatic logic is_cpu_phase(input state_e s);
        return s inside {RUN, WAIT_RUN};
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: synchronizes an async level and flags its rising edges, disarmed until a real low is seen after reset.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic [STAGES-1:0] fill_q, fill_d;
    logic              prev_q, prev_d;
    logic              armed_q, armed_d;
    logic              level;

    // fill_q marks when the synchronizer output holds a genuine post-reset sample,
    // so an input held high through reset release never looks like a fresh edge
    always_comb begin
        level   = sync_q[STAGES-1];
        sync_d  = (sync_q << 1) | STAGES'(async_in);
        fill_d  = (fill_q << 1) | STAGES'(1'b1);
        prev_d  = level;
        armed_d = armed_q | (fill_q[STAGES-1] & ~level);
        rise    = armed_q & level & ~prev_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fill_q  <= fill_d;
            prev_q  <= prev_d;
            armed_q <= armed_d;
        end
    end

endmodule

// File: rtl/io_sequencer.sv
// io_sequencer: runs load-instr / load-image / core run / transmit phases with a per-phase watchdog and a shared RAM mux.
module io_sequencer
    import io_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 32'd100_000_000,
    parameter int          SYNC_STAGES    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        load_instr,
    input  logic        tx_done,
    input  logic        rxin_done,
    input  logic        rxim_done,
    output logic        send,
    output logic        rec_in,
    output logic        rec_im,
    output logic        proc_start,
    input  logic        proc_done,
    input  logic [15:0] io_addr,
    input  logic [15:0] io_wdata,
    input  logic        io_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    input  logic        cpu_we,
    output logic [15:0] ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    output logic        ram_sel,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [3:0]  phase
);

    state_e      state_q, state_d;
    logic [31:0] wd_q, wd_d;
    logic        start_rise;
    logic        counting;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (start_btn),
        .rise     (start_rise)
    );

    always_comb begin
        state_d  = state_q;
        counting = is_io_phase(state_q) | (state_q == WAIT_RUN);
        case (state_q)
            IDLE, DONE, ERROR: if (start_rise) state_d = load_instr ? REQ_IN : REQ_IM;
            REQ_IN:            if (!rxin_done) state_d = WAIT_IN;
            WAIT_IN:           if (rxin_done)  state_d = REQ_IM;
            REQ_IM:            if (!rxim_done) state_d = WAIT_IM;
            WAIT_IM:           if (rxim_done)  state_d = RUN;
            RUN:               state_d = WAIT_RUN;
            WAIT_RUN:          if (proc_done)  state_d = REQ_TX;
            REQ_TX:            if (!tx_done)   state_d = WAIT_TX;
            WAIT_TX:           if (tx_done)    state_d = DONE;
            default:           state_d = IDLE;
        endcase
        // a handshake transition in the expiry cycle takes precedence over the timeout
        if (counting && state_d == state_q && wd_q == TIMEOUT_CYCLES - 32'd1) state_d = ERROR;
        wd_d = (state_d != state_q) ? 32'd0 : counting ? wd_q + 32'd1 : wd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wd_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        rec_in     = state_q == REQ_IN;
        rec_im     = state_q == REQ_IM;
        send       = state_q == REQ_TX;
        proc_start = state_q == RUN;
        busy       = !(state_q inside {IDLE, DONE, ERROR});
        done       = state_q == DONE;
        error      = state_q == ERROR;
        phase      = state_q;
        ram_sel    = is_cpu_phase(state_q);
        ram_addr   = ram_sel ? cpu_addr : io_addr;
        ram_wdata  = ram_sel ? cpu_wdata : io_wdata;
        ram_we     = ram_sel ? cpu_we : (is_io_phase(state_q) & io_we);
    end

endmodule
